// File: rtl/half_nn_pkg.sv
// Shared types and constants for the half-precision network sequencer.
package half_nn_pkg;

  localparam int          HALF_NEURONS = 10;
  localparam logic [15:0] HALF_ZERO    = 16'h0000;

  typedef logic [15:0] half_t;
  typedef half_t half_vec_t [HALF_NEURONS];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/half_vec_reg.sv
// NEURONS-wide half-float vector register with load enable and sync clear.
module half_vec_reg
  import half_nn_pkg::*;
#(
  parameter int NEURONS = HALF_NEURONS
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                load,
  input  half_t [NEURONS-1:0] d,
  output half_t [NEURONS-1:0] q
);

  half_t [NEURONS-1:0] q_r;

  // Vector storage: reset and clear win over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_r <= {NEURONS{HALF_ZERO}};
    end else if (clr) begin
      q_r <= {NEURONS{HALF_ZERO}};
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/half_predict_sequencer.sv
// Runs NUM_LAYERS invocations of one shared layer datapath per prediction.
// Optional per-layer watchdog enabled with `define HALF_SEQ_WDOG_EN.
module half_predict_sequencer
  import half_nn_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int NEURONS    = 10,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  half_t [NEURONS-1:0] x,
  output logic                busy,
  output logic                done,
  output half_t [NEURONS-1:0] y,
  output logic                lyr_start,
  output logic [IDX_W-1:0]    lyr_idx,
  output half_t [NEURONS-1:0] lyr_x,
  input  logic                lyr_done,
  input  half_t [NEURONS-1:0] lyr_l,
  output logic                err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  seq_state_t          state_r;
  seq_state_t          state_s;
  logic                busy_r;
  logic                done_r;
  logic                lyr_start_r;
  logic [IDX_W-1:0]    lyr_idx_r;
  logic                buf_load_s;
  logic                buf_sel_l_s;
  logic                y_load_s;
  logic                idx_clr_s;
  logic                idx_inc_s;
  logic                wd_fire_s;
  half_t [NEURONS-1:0] buf_d_s;

  // Next-state decode plus load strobes for the buffer, y and the index.
  always_comb begin
    state_s     = state_r;
    buf_load_s  = 1'b0;
    buf_sel_l_s = 1'b0;
    y_load_s    = 1'b0;
    idx_clr_s   = 1'b0;
    idx_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          buf_load_s = 1'b1;
          idx_clr_s  = 1'b1;
          state_s    = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      // A lyr_done seen here belongs to an earlier invocation and is dropped.
      LAUNCH: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (lyr_done) begin
          if (lyr_idx_r == LAST_IDX) begin
            y_load_s = 1'b1;
            state_s  = FINISH;
          end else begin
            buf_load_s  = 1'b1;
            buf_sel_l_s = 1'b1;
            idx_inc_s   = 1'b1;
            state_s     = LAUNCH;
          end
        end else if (wd_fire_s) begin
          state_s = FINISH;
        end else begin
          state_s = WAIT;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Layer input comes from x on accept and from the previous result afterwards.
  always_comb begin
    buf_d_s = x;
    if (buf_sel_l_s) begin
      buf_d_s = lyr_l;
    end else begin
      buf_d_s = x;
    end
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      lyr_start_r <= 1'b0;
      lyr_idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s == LAUNCH) || (state_s == WAIT);
      done_r      <= (state_s == FINISH);
      lyr_start_r <= (state_s == LAUNCH);
      if (idx_clr_s) begin
        lyr_idx_r <= {IDX_W{1'b0}};
      end else if (idx_inc_s) begin
        lyr_idx_r <= lyr_idx_r + IDX_ONE;
      end else begin
        lyr_idx_r <= lyr_idx_r;
      end
    end
  end

`ifdef HALF_SEQ_WDOG_EN
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] wd_cnt_r;
  logic             err_r;

  // wd_cnt_r holds cycles elapsed since lyr_start, so expiry lands done exactly TIMEOUT after it.
  assign wd_fire_s = (state_r == WAIT) && !lyr_done && (wd_cnt_r >= CNT_LIMIT);

  // Per-layer cycle counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_cnt_r <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (state_r == LAUNCH) begin
        wd_cnt_r <= CNT_ONE;
      end else if (state_r == WAIT) begin
        wd_cnt_r <= wd_cnt_r + CNT_ONE;
      end else begin
        wd_cnt_r <= {CNT_W{1'b0}};
      end
      if ((state_r == IDLE) && start) begin
        err_r <= 1'b0;
      end else if (wd_fire_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`else
  assign wd_fire_s = 1'b0;
  assign err       = 1'b0;
`endif

  half_vec_reg #(.NEURONS(NEURONS)) u_lyr_x_buf (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .load (buf_load_s),
    .d    (buf_d_s),
    .q    (lyr_x)
  );

  half_vec_reg #(.NEURONS(NEURONS)) u_y_reg (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .load (y_load_s),
    .d    (lyr_l),
    .q    (y)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign lyr_start = lyr_start_r;
  assign lyr_idx   = lyr_idx_r;

endmodule

// File: tb/tb_half_predict_sequencer.sv
// Randomized bench for half_predict_sequencer: a two-layer and a one-layer instance,
// each driven by a behavioural layer datapath and checked against an event-level model.
`timescale 1ns/1ps
module tb_half_predict_sequencer;
  import half_nn_pkg::*;

  localparam int          N    = 10;
  localparam int          W    = 16 * N;
  localparam int          TO   = 16;
  localparam logic [W-1:0] FLIP = {N{16'h0001}};
`ifdef HALF_SEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         start2 = 1'b0, ld2 = 1'b0;
  logic [W-1:0] x2 = '0, ll2 = '0;
  logic         busy2, done2, ls2, err2;
  logic [W-1:0] y2, lx2;
  logic [0:0]   li2;

  logic         start1 = 1'b0, ld1 = 1'b0;
  logic [W-1:0] x1 = '0, ll1 = '0;
  logic         busy1, done1, ls1, err1;
  logic [W-1:0] y1, lx1;
  logic [0:0]   li1;

  half_predict_sequencer #(.NUM_LAYERS(2), .NEURONS(N), .TIMEOUT(TO)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .x(x2), .busy(busy2), .done(done2), .y(y2),
    .lyr_start(ls2), .lyr_idx(li2), .lyr_x(lx2), .lyr_done(ld2), .lyr_l(ll2), .err(err2));

  half_predict_sequencer #(.NUM_LAYERS(1), .NEURONS(N), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .x(x1), .busy(busy1), .done(done1), .y(y1),
    .lyr_start(ls1), .lyr_idx(li1), .lyr_x(lx1), .lyr_done(ld1), .lyr_l(ll1), .err(err1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  // Behavioural layer datapaths: result = input XOR 1 per element, lat cycles after lyr_start.
  int lat2 = 5, cnt2 = 0, lat1 = 1, cnt1 = 0;
  bit pend2 = 0, mute2 = 0, stale2 = 0, pend1 = 0;
  logic [W-1:0] cap2 = '0, cap1 = '0;
  always @(negedge clk) begin
    ld2 = 1'b0;
    ll2 = rnd_vec();
    if (pend2) begin
      cnt2--;
      if (cnt2 == 0) begin pend2 = 0; ld2 = 1'b1; ll2 = cap2 ^ FLIP; end
    end
    if (ls2 === 1'b1) begin
      if (!mute2) begin pend2 = 1; cnt2 = lat2; cap2 = lx2; end
      if (stale2) begin stale2 = 0; ld2 = 1'b1; ll2 = {N{16'hBAD0}}; end
    end
    ld1 = 1'b0;
    ll1 = rnd_vec();
    if (pend1) begin
      cnt1--;
      if (cnt1 == 0) begin pend1 = 0; ld1 = 1'b1; ll1 = cap1 ^ FLIP; end
    end
    if (ls1 === 1'b1) begin pend1 = 1; cnt1 = lat1; cap1 = lx1; end
  end

  // Reference model: what each output must be in the cycle after this edge.
  bit           m_act = 0, m_launch = 0, m_fin = 0, m_err = 0;
  int           m_layer = 0, m_lcyc = 0, cyc = 0, d1_at = -1;
  logic [W-1:0] m_in = '0, m_y = '0, y1e = '0;
  always @(posedge clk) begin
    bit nx_launch, nx_fin;
    nx_launch = 0;
    nx_fin    = 0;
    if (!rstn) begin
      m_act = 0; m_layer = 0; m_in = '0; m_y = '0; m_err = 0;
    end else if (m_act) begin
      if (m_launch) m_lcyc = cyc;
      else if (ld2) begin
        if (m_layer == 1) begin m_y = ll2; m_act = 0; nx_fin = 1; end
        else begin m_in = ll2; m_layer = m_layer + 1; nx_launch = 1; end
      end else if (WD && (cyc + 1 - m_lcyc == TO)) begin
        m_act = 0; nx_fin = 1; m_err = 1;
      end
    end else if (!m_fin && start2) begin
      m_act = 1; nx_launch = 1; m_layer = 0; m_in = x2; m_err = 0;
    end
    m_launch = nx_launch;
    m_fin    = nx_fin;
    if (!rstn) d1_at = -1;
    else if (ld1) begin d1_at = cyc + 1; y1e = ll1; end
    cyc = cyc + 1;
  end

  // Cycle-by-cycle comparison plus event logs for the directed checks.
  bit           cmp_en = 0;
  int           ls_log[$], done_log[$], li_log[$];
  logic [W-1:0] lx_log[$];
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy2, m_act);
      check("done", done2, m_fin);
      check("lyr_start", ls2, m_launch);
      check("lyr_idx", li2, m_layer);
      check("lyr_x", lx2, m_in);
      check("y", y2, m_y);
      check("err", err2, m_err);
      check("n1_done", done1, (cyc == d1_at));
      check("n1_idx", li1, 0);
      if (done1 === 1'b1) check("n1_y", y1, y1e);
    end
    if (ls2 === 1'b1) begin ls_log.push_back(cyc); li_log.push_back(li2); lx_log.push_back(lx2); end
    if (done2 === 1'b1) done_log.push_back(cyc);
  end

  task automatic clear_logs();
    ls_log.delete(); done_log.delete(); li_log.delete(); lx_log.delete();
  endtask

  task automatic pulse_start2(input logic [W-1:0] v);
    x2 = v; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit one, input int lim, input string nm);
    int k = 0;
    while (((one ? done1 : done2) !== 1'b1) && (k < lim)) begin @(negedge clk); k++; end
    check(nm, one ? done1 : done2, 1'b1);
  endtask

  initial begin
    int t;
    int lats[3];
    logic [W-1:0] xa, xb, yk;
    lats = '{1, 3, 17};
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_lyr_start", ls2, 0);
    check("rst_lyr_x", lx2, 0);
    check("rst_y", y2, 0);
    check("rst_err", err2, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-layer run with x = 1.0 everywhere.
    clear_logs(); lat2 = 5; t = cyc;
    pulse_start2({N{16'h3C00}});
    wait_done(0, 60, "t1_done_timeout");
    repeat (2) @(negedge clk);
    check("t1_nstart", ls_log.size(), 2);
    check("t1_ndone", done_log.size(), 1);
    if (ls_log.size() == 2) begin
      check("t1_start0_cyc", ls_log[0], t + 1);
      check("t1_start1_cyc", ls_log[1], t + 7);
      check("t1_idx0", li_log[0], 0);
      check("t1_idx1", li_log[1], 1);
      check("t1_lyr_x0", lx_log[0], {N{16'h3C00}});
      check("t1_lyr_x1", lx_log[1], {N{16'h3C01}});
    end
    if (done_log.size() == 1) check("t1_done_cyc", done_log[0], t + 13);
    check("t1_y", y2, {N{16'h3C00}});

    // Start while busy and in the FINISH cycle is ignored.
    clear_logs(); lat2 = 4; xa = rnd_vec(); xb = rnd_vec();
    pulse_start2(xa);
    x2 = xb;
    repeat (2) @(negedge clk);
    pulse_start2(xb);
    wait_done(0, 60, "t2_done_timeout");
    pulse_start2(xb);
    repeat (4) @(negedge clk);
    check("t2_nstart", ls_log.size(), 2);
    check("t2_ndone", done_log.size(), 1);
    check("t2_y", y2, xa);

    // Stale lyr_done during the LAUNCH cycle.
    clear_logs(); lat2 = 3; xa = rnd_vec(); stale2 = 1;
    pulse_start2(xa);
    wait_done(0, 60, "t3_done_timeout");
    repeat (2) @(negedge clk);
    check("t3_nstart", ls_log.size(), 2);
    check("t3_y", y2, xa);

    // Reset while waiting on layer 1; its late lyr_done must be ignored.
    clear_logs(); lat2 = 6;
    pulse_start2(rnd_vec());
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("t4_busy", busy2, 0);
    check("t4_lyr_idx", li2, 0);
    check("t4_lyr_x", lx2, 0);
    check("t4_y", y2, 0);
    repeat (10) @(negedge clk);
    check("t4_ndone", done_log.size(), 0);
    check("t4_y_after", y2, 0);

    // Randomized runs with spurious starts and stale completions.
    for (int i = 0; i < 20; i++) begin
      lat2 = $urandom_range(1, 8);
      xa = rnd_vec();
      stale2 = (lat2 >= 2) && ($urandom_range(0, 1) == 1);
      pulse_start2(xa);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start2 = 1'($urandom_range(0, 1)); x2 = rnd_vec();
      @(negedge clk);
      start2 = 1'b0;
      wait_done(0, 80, "rnd_done_timeout");
      check("rnd_y", y2, xa);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

`ifdef HALF_SEQ_WDOG_EN
    // Watchdog: datapath never answers.
    clear_logs(); mute2 = 1; yk = y2;
    pulse_start2(rnd_vec());
    wait_done(0, 40, "wd_done_timeout");
    check("wd_err", err2, 1);
    check("wd_y_kept", y2, yk);
    if ((ls_log.size() == 1) && (done_log.size() == 1))
      check("wd_delay", done_log[0] - ls_log[0], TO);
    @(negedge clk);
    check("wd_idle", busy2, 0);
    check("wd_err_sticky", err2, 1);
    mute2 = 0; lat2 = 3; xa = rnd_vec();
    pulse_start2(xa);
    check("wd_err_clear", err2, 0);
    wait_done(0, 40, "wd2_done_timeout");
    check("wd2_y", y2, xa);
    repeat (2) @(negedge clk);
`endif

    // Single-layer instance, variable datapath latency.
    for (int i = 0; i < 3; i++) begin
      lat1 = lats[i]; xa = rnd_vec(); t = cyc;
      x1 = xa; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(1, 60, "n1_done_timeout");
      check("n1_done_cyc", cyc, t + lat1 + 2);
      check("n1_y_val", y1, xa ^ FLIP);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
